// File: rtl/cpwm_param_nch_shadow.sv
// Multi-channel complementary PWM generator.
// Each channel has a carrier counter (up, down or up-down), double-buffered
// period/compare registers and an A/B dead-time pair. A synchronised, latched
// fault trip gates every gate output. A prescaled, masked zero-event interrupt
// is also provided.
module cpwm_param_nch_shadow #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16,
  parameter int DT_W  = 8,
  parameter int EVT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sync_start,
  input  logic [N_CH*CNT_W-1:0]   period_x,
  input  logic [N_CH*CNT_W-1:0]   compare_x,
  input  logic [N_CH*CNT_W-1:0]   initcarr_x,
  input  logic [N_CH*DT_W-1:0]    dtime_A_x,
  input  logic [N_CH*DT_W-1:0]    dtime_B_x,
  input  logic [2*N_CH-1:0]       countmode_x,
  input  logic [2*N_CH-1:0]       loadmode_x,
  input  logic [N_CH-1:0]         int_mask,
  input  logic [EVT_W-1:0]        evt_prescale,
  input  logic                    fault_n,
  input  logic                    fault_clr,
  output logic [N_CH-1:0]         pwmout_A_x,
  output logic [N_CH-1:0]         pwmout_B_x,
  output logic [N_CH*CNT_W-1:0]   carrier_x,
  output logic                    fault_latched,
  output logic                    interrupt
);

  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [DT_W:0]    DT_ONE  = (DT_W+1)'(1);
  localparam logic [EVT_W:0]   EVT_ONE = (EVT_W+1)'(1);
  localparam logic [EVT_W-1:0] EVT_MIN = EVT_W'(1);

  logic             r_sync_1;
  logic             r_sync_2;
  logic             r_fault;
  logic             r_int;
  logic [EVT_W-1:0] r_evt;
  logic [N_CH-1:0]  w_zero;
  logic             w_evt_hit;
  logic [EVT_W-1:0] w_thr;
  logic [EVT_W:0]   w_evt_inc;

  for (genvar j = 0; j < N_CH; j++) begin : g_ch
    logic [CNT_W-1:0] w_per_in;
    logic [CNT_W-1:0] w_cmp_in;
    logic [CNT_W-1:0] w_init;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_cmp;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [DT_W-1:0]  w_dta;
    logic [DT_W-1:0]  w_dtb;
    logic [DT_W-1:0]  r_run_a;
    logic [DT_W-1:0]  r_run_b;
    logic [DT_W:0]    w_run_a_inc;
    logic [DT_W:0]    w_run_b_inc;
    logic [1:0]       w_cmode;
    logic [1:0]       w_lmode;
    logic             r_up;
    logic             w_up_nxt;
    logic             w_turn_up;
    logic             w_prd;
    logic             w_load;
    logic             r_raw;
    logic             r_a;
    logic             r_b;

    assign w_per_in = period_x[CNT_W*j +: CNT_W];
    assign w_cmp_in = compare_x[CNT_W*j +: CNT_W];
    assign w_init   = initcarr_x[CNT_W*j +: CNT_W];
    assign w_dta    = dtime_A_x[DT_W*j +: DT_W];
    assign w_dtb    = dtime_B_x[DT_W*j +: DT_W];
    assign w_cmode  = countmode_x[2*j +: 2];
    assign w_lmode  = loadmode_x[2*j +: 2];

    assign w_zero[j] = (r_cnt == '0);
    assign w_prd     = (r_cnt == r_per);
    // loadmode 00 loads every cycle, bit0 selects zero, bit1 selects period
    assign w_load    = (w_lmode == 2'b00) | (w_lmode[0] & w_zero[j]) | (w_lmode[1] & w_prd);

    // run lengths include the current cycle; MSB set means the counter saturates
    assign w_run_a_inc = {1'b0, r_run_a} + DT_ONE;
    assign w_run_b_inc = {1'b0, r_run_b} + DT_ONE;

    // next carrier value and direction: sync_start, then hold, then count mode
    always_comb begin
      w_cnt_nxt = r_cnt;
      w_up_nxt  = r_up;
      w_turn_up = r_up;
      if (sync_start) begin
        w_cnt_nxt = (w_init > r_per) ? r_per : w_init;
        w_up_nxt  = 1'b1;
      end else if (enable) begin
        case (w_cmode)
          2'b01: w_cnt_nxt = (r_cnt >= r_per) ? '0 : r_cnt + C_ONE;
          2'b10: w_cnt_nxt = (r_cnt == '0) ? r_per : r_cnt - C_ONE;
          2'b11: begin
            if (r_per == '0) begin
              w_cnt_nxt = '0;
            end else begin
              if (r_cnt == '0) begin
                w_turn_up = 1'b1;
              end else if (r_cnt >= r_per) begin
                w_turn_up = 1'b0;
              end
              w_cnt_nxt = w_turn_up ? r_cnt + C_ONE : r_cnt - C_ONE;
              w_up_nxt  = w_turn_up;
            end
          end
          default: ;
        endcase
      end
    end

    // carrier register and up-down direction
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
        r_up  <= 1'b1;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_up  <= w_up_nxt;
      end
    end

    // active period/compare copy the shadow inputs on the selected event
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_per <= '0;
        r_cmp <= '0;
      end else if (w_load) begin
        r_per <= w_per_in;
        r_cmp <= w_cmp_in;
      end
    end

    // registered raw compare, then dead-time qualification of A and B
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_raw   <= 1'b0;
        r_run_a <= '0;
        r_run_b <= '0;
        r_a     <= 1'b0;
        r_b     <= 1'b0;
      end else begin
        r_raw <= (r_cnt < r_cmp);
        if (!enable) begin
          r_run_a <= '0;
          r_run_b <= '0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end else begin
          r_run_a <= r_raw ? (w_run_a_inc[DT_W] ? r_run_a : w_run_a_inc[DT_W-1:0]) : '0;
          r_run_b <= r_raw ? '0 : (w_run_b_inc[DT_W] ? r_run_b : w_run_b_inc[DT_W-1:0]);
          r_a     <= r_raw & (w_run_a_inc >= {1'b0, w_dta});
          r_b     <= ~r_raw & (w_run_b_inc >= {1'b0, w_dtb});
        end
      end
    end

    assign carrier_x[CNT_W*j +: CNT_W] = r_cnt;
    assign pwmout_A_x[j] = r_a & ~r_fault;
    assign pwmout_B_x[j] = r_b & ~r_fault;
  end

  // fault_n synchroniser and trip latch; a trip wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_1 <= 1'b1;
      r_sync_2 <= 1'b1;
      r_fault  <= 1'b0;
    end else begin
      r_sync_1 <= fault_n;
      r_sync_2 <= r_sync_1;
      if (!r_sync_2) begin
        r_fault <= 1'b1;
      end else if (fault_clr) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign w_evt_hit = |(w_zero & int_mask);
  assign w_thr     = (evt_prescale == '0) ? EVT_MIN : evt_prescale;
  assign w_evt_inc = {1'b0, r_evt} + EVT_ONE;

  // event prescaler: one pulse per w_thr event cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_evt <= '0;
      r_int <= 1'b0;
    end else if (w_evt_hit) begin
      if (w_evt_inc >= {1'b0, w_thr}) begin
        r_evt <= '0;
        r_int <= 1'b1;
      end else begin
        r_evt <= w_evt_inc[EVT_W-1:0];
        r_int <= 1'b0;
      end
    end else begin
      r_int <= 1'b0;
    end
  end

  assign fault_latched = r_fault;
  assign interrupt     = r_int;

endmodule

// File: tb/tb_cpwm_param_nch_shadow.sv
// Bench for cpwm_param_nch_shadow: directed scenarios followed by random
// stimulus, compared every cycle against a behavioural model of the channel
// rules, plus a few hand-computed literal expectations.
module tb_cpwm_param_nch_shadow;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int DW = 8;
  localparam int EW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic            sync_start = 1'b0;
  logic [N*CW-1:0] period_x = '0;
  logic [N*CW-1:0] compare_x = '0;
  logic [N*CW-1:0] initcarr_x = '0;
  logic [N*DW-1:0] dtime_A_x = '0;
  logic [N*DW-1:0] dtime_B_x = '0;
  logic [2*N-1:0]  countmode_x = '0;
  logic [2*N-1:0]  loadmode_x = '0;
  logic [N-1:0]    int_mask = '0;
  logic [EW-1:0]   evt_prescale = '0;
  logic            fault_n = 1'b1;
  logic            fault_clr = 1'b0;
  logic [N-1:0]    pwmout_A_x;
  logic [N-1:0]    pwmout_B_x;
  logic [N*CW-1:0] carrier_x;
  logic            fault_latched;
  logic            interrupt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_cnt[N], m_up[N], m_per[N], m_cmp[N], m_raw[N], m_hi[N], m_lo[N], m_a[N], m_b[N];
  int m_f1, m_f2, m_flt, m_evt, m_int;

  cpwm_param_nch_shadow #(.N_CH(N), .CNT_W(CW), .DT_W(DW), .EVT_W(EW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync_start(sync_start),
    .period_x(period_x), .compare_x(compare_x), .initcarr_x(initcarr_x),
    .dtime_A_x(dtime_A_x), .dtime_B_x(dtime_B_x),
    .countmode_x(countmode_x), .loadmode_x(loadmode_x),
    .int_mask(int_mask), .evt_prescale(evt_prescale),
    .fault_n(fault_n), .fault_clr(fault_clr),
    .pwmout_A_x(pwmout_A_x), .pwmout_B_x(pwmout_B_x), .carrier_x(carrier_x),
    .fault_latched(fault_latched), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: one step per clock edge, inputs read as they stood before the edge
  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_cnt[j] = 0; m_up[j] = 1; m_per[j] = 0; m_cmp[j] = 0; m_raw[j] = 0;
      m_hi[j] = 0; m_lo[j] = 0; m_a[j] = 0; m_b[j] = 0;
    end
    m_f1 = 1; m_f2 = 1; m_flt = 0; m_evt = 0; m_int = 0;
  endtask

  task automatic model_step();
    int any, thr, p, c, cm, lm, ic, da, db;
    bit zero, pe, take;
    any = 0;
    for (int j = 0; j < N; j++) begin
      p  = m_per[j];
      c  = m_cnt[j];
      cm = countmode_x[2*j +: 2];
      lm = loadmode_x[2*j +: 2];
      ic = initcarr_x[CW*j +: CW];
      da = dtime_A_x[DW*j +: DW];
      db = dtime_B_x[DW*j +: DW];
      zero = (c == 0);
      pe   = (c == p);
      if (zero && int_mask[j]) any = 1;
      // dead time: consecutive-cycle run lengths of the registered compare
      if (!enable) begin
        m_hi[j] = 0; m_lo[j] = 0; m_a[j] = 0; m_b[j] = 0;
      end else begin
        m_hi[j] = m_raw[j] ? m_hi[j] + 1 : 0;
        m_lo[j] = m_raw[j] ? 0 : m_lo[j] + 1;
        m_a[j]  = (m_raw[j] != 0 && m_hi[j] >= da) ? 1 : 0;
        m_b[j]  = (m_raw[j] == 0 && m_lo[j] >= db) ? 1 : 0;
      end
      m_raw[j] = (c < m_cmp[j]) ? 1 : 0;
      // carrier
      if (sync_start) begin
        m_cnt[j] = (ic < p) ? ic : p;
        m_up[j]  = 1;
      end else if (enable) begin
        if (cm == 1) m_cnt[j] = (c >= p) ? 0 : c + 1;
        else if (cm == 2) m_cnt[j] = (c == 0) ? p : c - 1;
        else if (cm == 3 && p == 0) m_cnt[j] = 0;
        else if (cm == 3) begin
          if (c == 0) m_up[j] = 1;
          else if (c >= p) m_up[j] = 0;
          m_cnt[j] = m_up[j] ? c + 1 : c - 1;
        end
      end
      // shadow load
      take = (lm == 0) || (lm == 1 && zero) || (lm == 2 && pe) || (lm == 3 && (zero || pe));
      if (take) begin
        m_per[j] = period_x[CW*j +: CW];
        m_cmp[j] = compare_x[CW*j +: CW];
      end
    end
    if (m_f2 == 0) m_flt = 1;
    else if (fault_clr) m_flt = 0;
    m_f2 = m_f1;
    m_f1 = fault_n ? 1 : 0;
    thr = (evt_prescale == 0) ? 1 : int'(evt_prescale);
    m_int = 0;
    if (any != 0) begin
      m_evt++;
      if (m_evt >= thr) begin
        m_evt = 0;
        m_int = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // compare process: every falling edge
  initial begin
    logic [63:0] ec;
    logic [N-1:0] ea, eb;
    forever begin
      @(negedge clk);
      ec = '0; ea = '0; eb = '0;
      for (int j = 0; j < N; j++) begin
        ec[CW*j +: CW] = CW'(m_cnt[j]);
        ea[j] = (m_a[j] != 0) && (m_flt == 0);
        eb[j] = (m_b[j] != 0) && (m_flt == 0);
      end
      chk("carrier", carrier_x, ec);
      chk("pwm_A", 64'(pwmout_A_x), 64'(ea));
      chk("pwm_B", 64'(pwmout_B_x), 64'(eb));
      chk("fault_latched", 64'(fault_latched), 64'(m_flt != 0));
      chk("interrupt", 64'(interrupt), 64'(m_int != 0));
      chk("ab_overlap", 64'(pwmout_A_x & pwmout_B_x), 64'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setch(input int j, input int cm, input int lm, input int p, input int c,
                       input int da, input int db, input int ic);
    countmode_x[2*j +: 2]  = cm[1:0];
    loadmode_x[2*j +: 2]   = lm[1:0];
    period_x[CW*j +: CW]   = p[CW-1:0];
    compare_x[CW*j +: CW]  = c[CW-1:0];
    dtime_A_x[DW*j +: DW]  = da[DW-1:0];
    dtime_B_x[DW*j +: DW]  = db[DW-1:0];
    initcarr_x[CW*j +: CW] = ic[CW-1:0];
  endtask

  task automatic count_ab(input int ch, input int n, output int na, output int nb);
    na = 0; nb = 0;
    repeat (n) begin
      @(negedge clk);
      na += int'(pwmout_A_x[ch]);
      nb += int'(pwmout_B_x[ch]);
    end
  endtask

  task automatic count_irq(input int n, output int k);
    k = 0;
    repeat (n) begin
      @(negedge clk);
      k += int'(interrupt);
    end
  endtask

  task automatic wait_cnt(input int ch, input int v, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (carrier_x[CW*ch +: CW] != CW'(v) && k < 40);
    chk(nm, 64'(k < 40), 64'd1);
  endtask

  initial begin
    int na, nb, ni, c1a, mx;
    step(3);
    chk("reset_carrier", carrier_x, 64'd0);
    chk("reset_pwm", 64'({pwmout_A_x, pwmout_B_x}), 64'd0);
    chk("reset_fault", 64'(fault_latched), 64'd0);

    setch(0, 1, 0, 9, 4, 0, 0, 0);
    setch(1, 3, 0, 8, 3, 2, 1, 0);
    setch(2, 1, 0, 9, 4, 0, 0, 0);
    setch(3, 2, 0, 5, 2, 1, 1, 0);
    int_mask = 4'b0101;
    evt_prescale = 4'd3;
    reset = 1'b1;
    step(1);
    sync_start = 1'b1;
    step(1);
    sync_start = 1'b0;
    enable = 1'b1;
    step(25);

    // first A edge two clocks after the carrier reaches 0
    wait_cnt(0, 0, "wait_ch0_zero");
    chk("A_at_cnt0", 64'(pwmout_A_x[0]), 64'd0);
    @(negedge clk);
    chk("A_at_cnt1", 64'(pwmout_A_x[0]), 64'd0);
    @(negedge clk);
    chk("A_at_cnt2", 64'(pwmout_A_x[0]), 64'd1);

    count_ab(0, 10, na, nb);
    chk("ch0_A_high", 64'(na), 64'd4);
    chk("ch0_B_high", 64'(nb), 64'd6);

    c1a = int'(carrier_x[CW*1 +: CW]);
    mx = 0; na = 0; nb = 0;
    repeat (16) begin
      @(negedge clk);
      if (int'(carrier_x[CW*1 +: CW]) > mx) mx = int'(carrier_x[CW*1 +: CW]);
      na += int'(pwmout_A_x[1]);
      nb += int'(pwmout_B_x[1]);
    end
    chk("ch1_period16", 64'(carrier_x[CW*1 +: CW]), 64'(c1a));
    chk("ch1_peak", 64'(mx), 64'd8);
    chk("ch1_A_high", 64'(na), 64'd4);
    chk("ch1_B_high", 64'(nb), 64'd11);

    count_irq(90, ni);
    chk("irq_presc3", 64'(ni), 64'd3);
    step(1);
    evt_prescale = 4'd0;
    step(10);
    count_irq(30, ni);
    chk("irq_presc0", 64'(ni), 64'd3);

    // shadow load on zero: compare 4 -> 7 while the carrier is at 5
    step(1);
    loadmode_x[1:0] = 2'b01;
    wait_cnt(0, 5, "wait_ch0_five");
    #1;
    compare_x[CW*0 +: CW] = 16'd7;
    count_ab(0, 4, na, nb);
    chk("lm01_before_zero", 64'(na), 64'd0);
    count_ab(0, 10, na, nb);
    chk("lm01_after_zero", 64'(na), 64'd7);
    #1;
    loadmode_x[1:0] = 2'b00;
    compare_x[CW*0 +: CW] = 16'd2;
    step(12);
    count_ab(0, 10, na, nb);
    chk("lm00_immediate", 64'(na), 64'd2);
    #1;
    compare_x[CW*0 +: CW] = 16'd4;

    // C=1 with dtime_A=2 on the up-down channel: A suppressed
    compare_x[CW*1 +: CW] = 16'd1;
    step(20);
    count_ab(1, 16, na, nb);
    chk("ch1_A_suppressed", 64'(na), 64'd0);
    chk("ch1_B_long", 64'(nb), 64'd15);

    // fault trip, clear while tripped, clear after release
    step(1);
    fault_n = 1'b0;
    step(1);
    fault_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("fault_set", 64'(fault_latched), 64'd1);
    chk("fault_pwm_off", 64'({pwmout_A_x, pwmout_B_x}), 64'd0);
    step(1);
    fault_n = 1'b0;
    fault_clr = 1'b1;
    step(4);
    chk("fault_clr_blocked", 64'(fault_latched), 64'd1);
    fault_n = 1'b1;
    step(5);
    chk("fault_cleared", 64'(fault_latched), 64'd0);
    fault_clr = 1'b0;
    count_ab(0, 10, na, nb);
    chk("fault_resume_A", 64'(na), 64'd4);

    // sync_start with initcarr above period
    step(1);
    initcarr_x[CW*0 +: CW] = 16'd12;
    sync_start = 1'b1;
    step(1);
    sync_start = 1'b0;
    chk("sync_clamp", 64'(carrier_x[CW*0 +: CW]), 64'd9);
    initcarr_x[CW*0 +: CW] = 16'd0;

    // random phase
    for (int it = 0; it < 2500; it++) begin
      step(1);
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 39) == 0)
          setch(j, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 20)), int'($urandom_range(0, 22)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 25)));
      end
      sync_start = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      fault_n = ($urandom_range(0, 149) != 0);
      fault_clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        int_mask = N'($urandom);
        evt_prescale = EW'($urandom);
      end
    end

    // asynchronous reset mid-run
    sync_start = 1'b0;
    enable = 1'b1;
    fault_n = 1'b1;
    fault_clr = 1'b1;
    for (int j = 0; j < N; j++) setch(j, 1, 0, 9, 4, 0, 0, 0);
    step(20);
    fault_clr = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("async_carrier", carrier_x, 64'd0);
    chk("async_pwm", 64'({pwmout_A_x, pwmout_B_x}), 64'd0);
    chk("async_fault_irq", 64'({fault_latched, interrupt}), 64'd0);
    step(3);
    reset = 1'b1;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
